// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode constants, sequencer state encoding and ctrl strobe bit map
// Optional feature macro: CTRL_SINGLE_STEP_EN (adds the IDLE state).
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
`ifdef CTRL_SINGLE_STEP_EN
    ST_IDLE = 4'd10,
`endif
    ST_HALT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU, CL_ALUI, CL_UNARY, CL_MULDIV, CL_LD, CL_LDI, CL_ST, CL_BR,
    CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } iclass_t;

  localparam int CTRL_W       = 28;
  localparam int C_PC_OUT     = 0;
  localparam int C_MAR_IN     = 1;
  localparam int C_INC_PC     = 2;
  localparam int C_Z_IN       = 3;
  localparam int C_ZLO_OUT    = 4;
  localparam int C_PC_IN      = 5;
  localparam int C_READ       = 6;
  localparam int C_MDR_IN     = 7;
  localparam int C_MDR_OUT    = 8;
  localparam int C_IR_IN      = 9;
  localparam int C_GRA        = 10;
  localparam int C_GRB        = 11;
  localparam int C_GRC        = 12;
  localparam int C_R_OUT      = 13;
  localparam int C_R_IN       = 14;
  localparam int C_Y_IN       = 15;
  localparam int C_C_OUT      = 16;
  localparam int C_BA_OUT     = 17;
  localparam int C_LO_IN      = 18;
  localparam int C_HI_IN      = 19;
  localparam int C_ZHI_OUT    = 20;
  localparam int C_CON_IN     = 21;
  localparam int C_LINK_IN    = 22;
  localparam int C_INPORT_OUT = 23;
  localparam int C_OUTPORT_IN = 24;
  localparam int C_HI_OUT     = 25;
  localparam int C_LO_OUT     = 26;
  localparam int C_WRITE      = 27;

  // Final step of each instruction class; stop and the IDLE/T0 return are decided there.
  function automatic state_t last_step(input iclass_t c);
    case (c)
      CL_NOP, CL_HALT:                       return ST_T2;
      CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO: return ST_T3;
      CL_UNARY, CL_JAL:                      return ST_T4;
      CL_ALU, CL_ALUI, CL_LDI:               return ST_T5;
      CL_MULDIV, CL_BR:                      return ST_T6;
      default:                               return ST_T7;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to instruction-class map
// Ports: opcode (in, 5) instruction opcode; cls (out) instruction class.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    cls
);

  always_comb begin
    cls = CL_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  cls = CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:         cls = CL_ALUI;
      OP_NEG, OP_NOT:                   cls = CL_UNARY;
      OP_MUL, OP_DIV:                   cls = CL_MULDIV;
      OP_LD:                            cls = CL_LD;
      OP_LDI:                           cls = CL_LDI;
      OP_ST:                            cls = CL_ST;
      OP_BR:                            cls = CL_BR;
      OP_JR:                            cls = CL_JR;
      OP_JAL:                           cls = CL_JAL;
      OP_IN:                            cls = CL_IN;
      OP_OUT:                           cls = CL_OUT;
      OP_MFHI:                          cls = CL_MFHI;
      OP_MFLO:                          cls = CL_MFLO;
      OP_HALT:                          cls = CL_HALT;
      default:                          cls = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/execute control FSM driving datapath strobes
// Ports: clk, reset (sync, active-high), opcode[4:0], con_ff, mem_ready, stop,
//        step (only with CTRL_SINGLE_STEP_EN); alu_op[4:0], ctrl[27:0], run, state[3:0].
// nop/halt resolve at T2, so opcode must already be valid during T2 for those two.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  opcode,
  input  logic        con_ff,
  input  logic        mem_ready,
  input  logic        stop,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic [4:0]  alu_op,
  output logic [27:0] ctrl,
  output logic        run,
  output logic [3:0]  state
);

`ifdef CTRL_SINGLE_STEP_EN
  localparam state_t AFTER_INSTR = ST_IDLE;
`else
  localparam state_t AFTER_INSTR = ST_T0;
`endif

  iclass_t cls;
  state_t  cur, nxt;
  logic    mem_wait;

  ctrl_decode u_decode (.opcode(opcode), .cls(cls));

  always_ff @(posedge clk) begin
    if (reset) cur <= ST_RST;
    else       cur <= nxt;
  end

  always_comb begin
    mem_wait = !mem_ready && ((cur == ST_T1) || (cur == ST_T6 && cls == CL_LD) ||
                              (cur == ST_T7 && cls == CL_ST));
    nxt = cur;
    case (cur)
      ST_RST:  nxt = ST_T0;
      ST_HALT: nxt = ST_HALT;
`ifdef CTRL_SINGLE_STEP_EN
      ST_IDLE: nxt = step ? ST_T0 : ST_IDLE;
`endif
      default: begin
        if (mem_wait)                  nxt = cur;
        else if (cur == last_step(cls)) nxt = (cls == CL_HALT || stop) ? ST_HALT : AFTER_INSTR;
        else                           nxt = state_t'(cur + 4'd1);
      end
    endcase
  end

  always_comb begin
    ctrl   = '0;
    alu_op = '0;
    case (cur)
      ST_T0: begin ctrl[C_PC_OUT] = 1'b1; ctrl[C_MAR_IN] = 1'b1; ctrl[C_INC_PC] = 1'b1; ctrl[C_Z_IN] = 1'b1; end
      ST_T1: begin ctrl[C_ZLO_OUT] = 1'b1; ctrl[C_PC_IN] = 1'b1; ctrl[C_READ] = 1'b1; ctrl[C_MDR_IN] = 1'b1; end
      ST_T2: begin ctrl[C_MDR_OUT] = 1'b1; ctrl[C_IR_IN] = 1'b1; end
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        case (cls)
          CL_ALU, CL_ALUI: begin
            if (cur == ST_T3) begin ctrl[C_GRB] = 1'b1; ctrl[C_R_OUT] = 1'b1; ctrl[C_Y_IN] = 1'b1; end
            if (cur == ST_T4) begin
              if (cls == CL_ALU) begin ctrl[C_GRC] = 1'b1; ctrl[C_R_OUT] = 1'b1; end
              else ctrl[C_C_OUT] = 1'b1;
              ctrl[C_Z_IN] = 1'b1; alu_op = opcode;
            end
            if (cur == ST_T5) begin ctrl[C_ZLO_OUT] = 1'b1; ctrl[C_GRA] = 1'b1; ctrl[C_R_IN] = 1'b1; end
          end
          CL_UNARY: begin
            if (cur == ST_T3) begin ctrl[C_GRB] = 1'b1; ctrl[C_R_OUT] = 1'b1; ctrl[C_Z_IN] = 1'b1; alu_op = opcode; end
            if (cur == ST_T4) begin ctrl[C_ZLO_OUT] = 1'b1; ctrl[C_GRA] = 1'b1; ctrl[C_R_IN] = 1'b1; end
          end
          CL_MULDIV: begin
            if (cur == ST_T3) begin ctrl[C_GRA] = 1'b1; ctrl[C_R_OUT] = 1'b1; ctrl[C_Y_IN] = 1'b1; end
            if (cur == ST_T4) begin ctrl[C_GRB] = 1'b1; ctrl[C_R_OUT] = 1'b1; ctrl[C_Z_IN] = 1'b1; alu_op = opcode; end
            if (cur == ST_T5) begin ctrl[C_ZLO_OUT] = 1'b1; ctrl[C_LO_IN] = 1'b1; end
            if (cur == ST_T6) begin ctrl[C_ZHI_OUT] = 1'b1; ctrl[C_HI_IN] = 1'b1; end
          end
          CL_LD, CL_LDI, CL_ST: begin
            // Shared effective-address calculation: base (or zero) + immediate.
            if (cur == ST_T3) begin ctrl[C_GRB] = 1'b1; ctrl[C_BA_OUT] = 1'b1; ctrl[C_Y_IN] = 1'b1; end
            if (cur == ST_T4) begin ctrl[C_C_OUT] = 1'b1; ctrl[C_Z_IN] = 1'b1; alu_op = OP_ADD; end
            if (cur == ST_T5) begin
              ctrl[C_ZLO_OUT] = 1'b1;
              if (cls == CL_LDI) begin ctrl[C_GRA] = 1'b1; ctrl[C_R_IN] = 1'b1; end
              else ctrl[C_MAR_IN] = 1'b1;
            end
            if (cur == ST_T6) begin
              if (cls == CL_LD) begin ctrl[C_READ] = 1'b1; ctrl[C_MDR_IN] = 1'b1; end
              if (cls == CL_ST) begin ctrl[C_GRA] = 1'b1; ctrl[C_R_OUT] = 1'b1; ctrl[C_MDR_IN] = 1'b1; end
            end
            if (cur == ST_T7) begin
              if (cls == CL_LD) begin ctrl[C_MDR_OUT] = 1'b1; ctrl[C_GRA] = 1'b1; ctrl[C_R_IN] = 1'b1; end
              if (cls == CL_ST) ctrl[C_WRITE] = 1'b1;
            end
          end
          CL_BR: begin
            if (cur == ST_T3) begin ctrl[C_GRA] = 1'b1; ctrl[C_R_OUT] = 1'b1; ctrl[C_CON_IN] = 1'b1; end
            if (cur == ST_T4) begin ctrl[C_PC_OUT] = 1'b1; ctrl[C_Y_IN] = 1'b1; end
            if (cur == ST_T5) begin ctrl[C_C_OUT] = 1'b1; ctrl[C_Z_IN] = 1'b1; alu_op = OP_ADD; end
            if (cur == ST_T6) begin ctrl[C_ZLO_OUT] = 1'b1; ctrl[C_PC_IN] = con_ff; end
          end
          CL_JR:   if (cur == ST_T3) begin ctrl[C_GRA] = 1'b1; ctrl[C_R_OUT] = 1'b1; ctrl[C_PC_IN] = 1'b1; end
          CL_JAL: begin
            if (cur == ST_T3) begin ctrl[C_PC_OUT] = 1'b1; ctrl[C_LINK_IN] = 1'b1; end
            if (cur == ST_T4) begin ctrl[C_GRA] = 1'b1; ctrl[C_R_OUT] = 1'b1; ctrl[C_PC_IN] = 1'b1; end
          end
          CL_IN:   if (cur == ST_T3) begin ctrl[C_INPORT_OUT] = 1'b1; ctrl[C_GRA] = 1'b1; ctrl[C_R_IN] = 1'b1; end
          CL_OUT:  if (cur == ST_T3) begin ctrl[C_GRA] = 1'b1; ctrl[C_R_OUT] = 1'b1; ctrl[C_OUTPORT_IN] = 1'b1; end
          CL_MFHI: if (cur == ST_T3) begin ctrl[C_HI_OUT] = 1'b1; ctrl[C_GRA] = 1'b1; ctrl[C_R_IN] = 1'b1; end
          CL_MFLO: if (cur == ST_T3) begin ctrl[C_LO_OUT] = 1'b1; ctrl[C_GRA] = 1'b1; ctrl[C_R_IN] = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    run = (cur != ST_RST) && (cur != ST_HALT);
`ifdef CTRL_SINGLE_STEP_EN
    if (cur == ST_IDLE) run = 1'b0;
`endif
  end

  assign state = cur;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized self-checking bench for control_sequencer
module tb_control_sequencer;
  import cpu_pkg::*;

  logic        clk, reset, con_ff, mem_ready, stop, step;
  logic [4:0]  opcode, alu_op;
  logic [27:0] ctrl;
  logic        run;
  logic [3:0]  state;
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct { logic [3:0] st; logic [27:0] ctl; logic [4:0] aop; bit mem; } step_t;
  step_t seq[$];

  control_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .con_ff(con_ff),
    .mem_ready(mem_ready), .stop(stop),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .alu_op(alu_op), .ctrl(ctrl), .run(run), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] b(input int i);
    return 28'd1 << i;
  endfunction

  task automatic add_step(input logic [3:0] s, input logic [27:0] c, input logic [4:0] a, input bit m);
    step_t e;
    e.st = s; e.ctl = c; e.aop = a; e.mem = m;
    seq.push_back(e);
  endtask

  // Expected micro-step list of one instruction, written straight from the instruction table.
  task automatic build_seq(input logic [4:0] op, input bit cf);
    logic [27:0] rd_a, rd_b, wr_a;
    rd_a = b(C_GRA) | b(C_R_OUT);
    rd_b = b(C_GRB) | b(C_R_OUT);
    wr_a = b(C_GRA) | b(C_R_IN);
    seq.delete();
    add_step(ST_T0, b(C_PC_OUT) | b(C_MAR_IN) | b(C_INC_PC) | b(C_Z_IN), 5'd0, 1'b0);
    add_step(ST_T1, b(C_ZLO_OUT) | b(C_PC_IN) | b(C_READ) | b(C_MDR_IN), 5'd0, 1'b1);
    add_step(ST_T2, b(C_MDR_OUT) | b(C_IR_IN), 5'd0, 1'b0);
    if (op >= 5'd3 && op <= 5'd11) begin
      add_step(ST_T3, rd_b | b(C_Y_IN), 5'd0, 1'b0);
      add_step(ST_T4, b(C_GRC) | b(C_R_OUT) | b(C_Z_IN), op, 1'b0);
      add_step(ST_T5, b(C_ZLO_OUT) | wr_a, 5'd0, 1'b0);
    end else if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI) begin
      add_step(ST_T3, rd_b | b(C_Y_IN), 5'd0, 1'b0);
      add_step(ST_T4, b(C_C_OUT) | b(C_Z_IN), op, 1'b0);
      add_step(ST_T5, b(C_ZLO_OUT) | wr_a, 5'd0, 1'b0);
    end else if (op == OP_NEG || op == OP_NOT) begin
      add_step(ST_T3, rd_b | b(C_Z_IN), op, 1'b0);
      add_step(ST_T4, b(C_ZLO_OUT) | wr_a, 5'd0, 1'b0);
    end else if (op == OP_MUL || op == OP_DIV) begin
      add_step(ST_T3, rd_a | b(C_Y_IN), 5'd0, 1'b0);
      add_step(ST_T4, rd_b | b(C_Z_IN), op, 1'b0);
      add_step(ST_T5, b(C_ZLO_OUT) | b(C_LO_IN), 5'd0, 1'b0);
      add_step(ST_T6, b(C_ZHI_OUT) | b(C_HI_IN), 5'd0, 1'b0);
    end else if (op == OP_LD || op == OP_LDI || op == OP_ST) begin
      add_step(ST_T3, b(C_GRB) | b(C_BA_OUT) | b(C_Y_IN), 5'd0, 1'b0);
      add_step(ST_T4, b(C_C_OUT) | b(C_Z_IN), 5'b00011, 1'b0);
      if (op == OP_LDI) add_step(ST_T5, b(C_ZLO_OUT) | wr_a, 5'd0, 1'b0);
      else add_step(ST_T5, b(C_ZLO_OUT) | b(C_MAR_IN), 5'd0, 1'b0);
      if (op == OP_LD) begin
        add_step(ST_T6, b(C_READ) | b(C_MDR_IN), 5'd0, 1'b1);
        add_step(ST_T7, b(C_MDR_OUT) | wr_a, 5'd0, 1'b0);
      end
      if (op == OP_ST) begin
        add_step(ST_T6, rd_a | b(C_MDR_IN), 5'd0, 1'b0);
        add_step(ST_T7, b(C_WRITE), 5'd0, 1'b1);
      end
    end else if (op == OP_BR) begin
      add_step(ST_T3, rd_a | b(C_CON_IN), 5'd0, 1'b0);
      add_step(ST_T4, b(C_PC_OUT) | b(C_Y_IN), 5'd0, 1'b0);
      add_step(ST_T5, b(C_C_OUT) | b(C_Z_IN), 5'b00011, 1'b0);
      add_step(ST_T6, b(C_ZLO_OUT) | (cf ? b(C_PC_IN) : 28'd0), 5'd0, 1'b0);
    end else if (op == OP_JR) begin
      add_step(ST_T3, rd_a | b(C_PC_IN), 5'd0, 1'b0);
    end else if (op == OP_JAL) begin
      add_step(ST_T3, b(C_PC_OUT) | b(C_LINK_IN), 5'd0, 1'b0);
      add_step(ST_T4, rd_a | b(C_PC_IN), 5'd0, 1'b0);
    end else if (op == OP_IN)   add_step(ST_T3, b(C_INPORT_OUT) | wr_a, 5'd0, 1'b0);
    else if (op == OP_OUT)      add_step(ST_T3, rd_a | b(C_OUTPORT_IN), 5'd0, 1'b0);
    else if (op == OP_MFHI)     add_step(ST_T3, b(C_HI_OUT) | wr_a, 5'd0, 1'b0);
    else if (op == OP_MFLO)     add_step(ST_T3, b(C_LO_OUT) | wr_a, 5'd0, 1'b0);
  endtask

  task automatic idle_step();
`ifdef CTRL_SINGLE_STEP_EN
    int k;
    k = $urandom_range(0, 2);
    for (int j = 0; j <= k; j++) begin
      step = 1'b0;
      check_eq("idle_state", state, ST_IDLE);
      check_eq("idle_run", run, 0);
      check_eq("idle_ctrl", ctrl, 0);
      tick();
    end
    step = 1'b1;
    check_eq("idle_state_step", state, ST_IDLE);
    tick();
    step = 1'b0;
`endif
  endtask

  task automatic expect_halted(input int cycles);
    for (int j = 0; j < cycles; j++) begin
      mem_ready = 1'($urandom_range(0, 1));
      stop      = 1'($urandom_range(0, 1));
      step      = 1'($urandom_range(0, 1));
      check_eq("halt_state", state, ST_HALT);
      check_eq("halt_ctrl", ctrl, 0);
      check_eq("halt_run", run, 0);
      tick();
    end
    stop = 1'b0; step = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    check_eq("rst_state", state, ST_RST);
    check_eq("rst_ctrl", ctrl, 0);
    check_eq("rst_run", run, 0);
    check_eq("rst_alu_op", alu_op, 0);
    reset = 1'b0;
    tick();
    check_eq("rst_to_t0", state, ST_T0);
  endtask

  // stop_mode: 0 never, 1 random on non-final steps, 2 held high from T3 onward.
  // stall: memory wait length per handshake, -1 for random 0..3.
  task automatic run_instr(input logic [4:0] op, input bit cf, input int stop_mode, input int stall);
    int  stalls;
    bit  last;
    build_seq(op, cf);
    opcode = op;
    con_ff = cf;
    for (int i = 0; i < seq.size(); i++) begin
      last   = (i == seq.size() - 1);
      stalls = !seq[i].mem ? 0 : (stall >= 0 ? stall : $urandom_range(0, 3));
      for (int w = 0; w <= stalls; w++) begin
        mem_ready = seq[i].mem ? (w == stalls) : 1'($urandom_range(0, 1));
        if (stop_mode == 1)      stop = last ? 1'b0 : 1'($urandom_range(0, 1));
        else if (stop_mode == 2) stop = (i >= 3);
        else                     stop = 1'b0;
        check_eq($sformatf("state op%0h s%0d", op, i), state, seq[i].st);
        check_eq($sformatf("ctrl op%0h s%0d", op, i), ctrl, seq[i].ctl);
        check_eq($sformatf("alu_op op%0h s%0d", op, i), alu_op, seq[i].aop);
        check_eq($sformatf("run op%0h s%0d", op, i), run, 1);
        tick();
      end
    end
    stop = 1'b0;
    if (op != OP_HALT && stop_mode != 2) idle_step();
  endtask

  initial begin
    logic [4:0] rop;
    reset = 1'b1; opcode = '0; con_ff = 1'b0; mem_ready = 1'b1; stop = 1'b0; step = 1'b0;
    tick();
    do_reset();

    run_instr(OP_ADD, 1'b0, 0, 0);
    run_instr(OP_ADD, 1'b0, 0, 0);
    run_instr(OP_LD, 1'b0, 0, 3);
    run_instr(OP_BR, 1'b0, 0, 0);
    run_instr(OP_BR, 1'b1, 0, 0);
    run_instr(OP_MUL, 1'b0, 0, 0);
    run_instr(OP_ST, 1'b0, 0, 2);

    for (int n = 0; n < 60; n++) begin
      rop = 5'($urandom_range(0, 31));
      if (rop == OP_HALT) rop = OP_NOP;
      run_instr(rop, 1'($urandom_range(0, 1)), 1, -1);
    end

    // reset asserted in T4 of div
    opcode = OP_DIV; mem_ready = 1'b1;
    for (int j = 0; j < 4; j++) tick();
    check_eq("div_t4", state, ST_T4);
    do_reset();

    // reset asserted while T1 waits on memory
    mem_ready = 1'b0;
    tick(); tick();
    check_eq("t1_wait", state, ST_T1);
    do_reset();

    // stop held from T3 of sub: sub finishes T5, then HALT
    run_instr(OP_SUB, 1'b0, 2, 0);
    expect_halted(3);
    do_reset();

    run_instr(OP_HALT, 1'b0, 0, 0);
    expect_halted(20);
    do_reset();
    run_instr(OP_NOP, 1'b0, 0, 0);
    run_instr(OP_ADDI, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: opcode  input  5  IR[31:27], sampled combinationally from T3 onward.
REQ-004 SHALL have port: con_ff  input  1  branch-condition flip-flop result.
REQ-005 SHALL have port: mem_ready  input  1  memory completion handshake.
REQ-006 SHALL have port: stop  input  1  external halt request.
REQ-007 SHALL have port: alu_op  output  5  opcode driven to ALU.
REQ-008 SHALL have port: ctrl  output  28  datapath strobe bundle; bit map fixed in package.
REQ-009 SHALL have port: run  output  1  high while executing.
REQ-010 SHALL have port: state  output  4  current FSM state, for debug.

Function
REQ-011 SHALL implement FSM states RST, T0..T7 and HALT.
REQ-012 SHALL advance exactly one state per clk, except in memory waits and HALT.
REQ-013 Fetch SHALL be: T0 pc_out+mar_in+inc_pc+z_in; T1 zlo_out+pc_in+read+mdr_in; T2 mdr_out+ir_in.
REQ-014 T1 SHALL hold, with read asserted, until mem_ready=1; it then proceeds to T2 on the next edge.
REQ-015 Register ALU ops (00011..01011) SHALL be: T3 grb+r_out+y_in; T4 grc+r_out+z_in, alu_op=opcode; T5 zlo_out+gra+r_in; then T0 (6 cycles total).
REQ-016 addi/andi/ori SHALL be as REQ-015, except T4 uses c_out instead of grc+r_out.
REQ-017 neg/not SHALL be: T3 grb+r_out+z_in, alu_op=opcode; T4 zlo_out+gra+r_in.
REQ-018 mul/div SHALL be: T3 gra+r_out+y_in; T4 grb+r_out+z_in, alu_op=opcode; T5 zlo_out+lo_in; T6 zhi_out+hi_in.
REQ-019 ld/ldi/st SHALL share T3 grb+ba_out+y_in and T4 c_out+z_in with alu_op=ADD.
REQ-020 ldi SHALL then run T5 zlo_out+gra+r_in.
REQ-021 ld SHALL then run T5 zlo_out+mar_in, T6 read+mdr_in (holds until mem_ready), T7 mdr_out+gra+r_in.
REQ-022 st SHALL then run T5 zlo_out+mar_in, T6 gra+r_out+mdr_in, T7 write (holds until mem_ready).
REQ-023 br SHALL be: T3 gra+r_out+con_in; T4 pc_out+y_in; T5 c_out+z_in, alu_op=ADD; T6 zlo_out, with pc_in only if con_ff=1.
REQ-024 jr SHALL be T3 gra+r_out+pc_in; jal SHALL be T3 pc_out+link_in, then T4 gra+r_out+pc_in.
REQ-025 in/out/mfhi/mflo SHALL each be a single T3 step: inport_out / outport_in / hi_out / lo_out, combined with gra+r_in or gra+r_out as appropriate.
REQ-026 nop and unused opcodes (11100..11111) SHALL return T2 -> T0.
REQ-027 halt SHALL go T2 -> HALT.
REQ-028 HALT SHALL be exited only by reset.
REQ-029 stop=1 SHALL be sampled only at the last execute step; the FSM then enters HALT instead of T0, so an instruction is never split.
REQ-030 ctrl SHALL be a pure decode of state, opcode, con_ff and mem_ready.
REQ-031 ctrl SHALL be all-zero in RST and HALT.
REQ-032 run SHALL be 0 in RST and HALT, and 1 otherwise.

Reset
REQ-033 reset=1 at a clk edge SHALL force state=RST from any state, including memory waits; the next cycle ctrl=0, run=0, alu_op=0.
REQ-034 RST SHALL be followed by T0 on the first edge with reset=0.

Configuration
REQ-035 When CTRL_SINGLE_STEP_EN is defined: input step (1 bit) SHALL be added; after each instruction's final step the FSM waits in HALT-like state IDLE (run=0) until step=1, then enters T0.
REQ-036 When CTRL_SINGLE_STEP_EN is absent: no step port and no IDLE state; the FSM proceeds directly to T0.

Structure
REQ-037 Package cpu_pkg SHALL hold the opcode constants, state encoding and ctrl bit indices, shared with the ALU and datapath.
REQ-038 Sub-module ctrl_decode SHALL map opcode to an instruction class (combinational).
REQ-039 The FSM and strobe generation SHALL reside in control_sequencer.

Verification
REQ-040 Reset, then add (00011) with mem_ready=1: states T0..T5 repeat; alu_op=00011 in T4; run=1; 6 cycles per instruction.
REQ-041 ld with mem_ready held low 3 cycles in T6: T6 persists 3 extra cycles with read=1, then T7 asserts mdr_out+gra+r_in.
REQ-042 br with con_ff=0, then con_ff=1: pc_in is 0, then 1, in T6.
REQ-043 mul: lo_in in T5 and hi_in in T6; halt: state=HALT with ctrl=0, and it remains there for 20 cycles.
REQ-044 reset pulsed in T4 of div: RST on the next cycle with ctrl=0, then T0 one cycle after reset drops.
REQ-045 stop raised mid-instruction during sub: sub completes T5, then HALT; with CTRL_SINGLE_STEP_EN, each step pulse executes exactly one instruction.
